// File: rtl/fp_cmp_pkg.sv
// fp_cmp_pkg: op/state encodings, recoded constants and flag positions shared by the compare arbiter
package fp_cmp_pkg;
  localparam logic [2:0] FP_CMP_FEQ  = 3'd0;
  localparam logic [2:0] FP_CMP_FLT  = 3'd1;
  localparam logic [2:0] FP_CMP_FLE  = 3'd2;
  localparam logic [2:0] FP_CMP_FMIN = 3'd3;
  localparam logic [2:0] FP_CMP_FMAX = 3'd4;
  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_e;
  localparam logic [32:0] CANON_NAN_REC = 33'h0_E040_0000;
  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;
  function automatic logic is_nan(input logic [32:0] x);
    return &x[31:29];
  endfunction
endpackage

// File: rtl/fp_compare_arbiter_if.sv
// fp_compare_arbiter_if: two request channels, one response channel and fflags control
interface fp_compare_arbiter_if #(parameter int TAG_W = 4);
  logic             req0_valid, req0_ready, req1_valid, req1_ready;
  logic [2:0]       req0_op, req1_op;
  logic [32:0]      req0_a, req0_b, req1_a, req1_b;
  logic [TAG_W-1:0] req0_tag, req1_tag;
  logic             resp_valid, resp_ready, resp_src;
  logic [TAG_W-1:0] resp_tag;
  logic [32:0]      resp_data;
  logic [4:0]       resp_flags, fflags_acc;
  logic             fflags_clr, flush;
  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b, req0_tag,
    input  req1_valid, req1_op, req1_a, req1_b, req1_tag,
    input  resp_ready, fflags_clr, flush,
    output req0_ready, req1_ready, resp_valid, resp_src, resp_tag, resp_data, resp_flags, fflags_acc
  );
  modport master (
    output req0_valid, req0_op, req0_a, req0_b, req0_tag,
    output req1_valid, req1_op, req1_a, req1_b, req1_tag,
    output resp_ready, fflags_clr, flush,
    input  req0_ready, req1_ready, resp_valid, resp_src, resp_tag, resp_data, resp_flags, fflags_acc
  );
endinterface

// File: rtl/fp_compare_core.sv
// fp_compare_core: combinational recFN(8/24) compare producing lt, eq and the invalid flag
module fp_compare_core
  import fp_cmp_pkg::*;
(
  input  logic [32:0] a,
  input  logic [32:0] b,
  input  logic        signaling,
  output logic        lt,
  output logic        eq,
  output logic [4:0]  flags
);
  logic a_nan, b_nan, a_snan, b_snan, both_inf, both_zero, ordered, eq_exp, lt_mag, eq_mag;
  assign a_nan     = is_nan(a);
  assign b_nan     = is_nan(b);
  assign a_snan    = a_nan & ~a[22];
  assign b_snan    = b_nan & ~b[22];
  assign both_inf  = (a[31:29] == 3'b110) & (b[31:29] == 3'b110);
  assign both_zero = (a[31:29] == 3'b000) & (b[31:29] == 3'b000);
  assign ordered   = ~a_nan & ~b_nan;
  assign eq_exp    = a[31:23] == b[31:23];
  assign lt_mag    = (a[31:23] < b[31:23]) | (eq_exp & (a[22:0] < b[22:0]));
  assign eq_mag    = eq_exp & (a[22:0] == b[22:0]);
  // infinities and zeros ignore magnitude bits; sign alone orders them
  assign lt = ordered & ~both_zero & ((a[32] & ~b[32]) |
              (~both_inf & ((a[32] & ~lt_mag & ~eq_mag) | (~b[32] & lt_mag))));
  assign eq = ordered & (both_zero | ((a[32] == b[32]) & (both_inf | eq_mag)));
  always_comb begin
    flags = '0;
    flags[FLAG_NV] = a_snan | b_snan | (signaling & ~ordered);
  end
endmodule

// File: rtl/fp_compare_arbiter.sv
// fp_compare_arbiter: round-robin shares one recoded FP compare between two requesters,
// three-state issue/exec/respond pipeline with sticky fflags accumulation
module fp_compare_arbiter
  import fp_cmp_pkg::*;
#(parameter int TAG_W = 4)
(
  input logic clock,
  input logic reset_n,
  fp_compare_arbiter_if.slave bus
);
  state_e state;
  logic last_grant, grant0, grant1, slot_free, accept, src_q, lt, eq, signaling;
  logic a_nan, b_nan, a_zero, b_zero;
  logic [2:0] op_q;
  logic [32:0] a_q, b_q, minmax, data;
  logic [TAG_W-1:0] tag_q;
  logic [4:0] core_flags, flags;
  assign grant0 = bus.req0_valid & (~bus.req1_valid | last_grant);
  assign grant1 = bus.req1_valid & (~bus.req0_valid | ~last_grant);
  assign slot_free = reset_n & ~bus.flush & ((state == ST_IDLE) | ((state == ST_RESP) & bus.resp_ready));
  assign bus.req0_ready = grant0 & slot_free;
  assign bus.req1_ready = grant1 & slot_free;
  assign accept = (grant0 | grant1) & slot_free;
  assign signaling = (op_q == FP_CMP_FLT) | (op_q == FP_CMP_FLE);
  fp_compare_core core (.a(a_q), .b(b_q), .signaling(signaling), .lt(lt), .eq(eq), .flags(core_flags));
  assign a_nan  = is_nan(a_q);
  assign b_nan  = is_nan(b_q);
  assign a_zero = a_q[31:29] == 3'b000;
  assign b_zero = b_q[31:29] == 3'b000;
  // opposite-signed zeros compare equal, so the sign picks the min/max result
  assign minmax = (a_nan & b_nan) ? CANON_NAN_REC : a_nan ? b_q : b_nan ? a_q
                : (a_zero & b_zero & (a_q[32] ^ b_q[32])) ? (((op_q == FP_CMP_FMIN) == a_q[32]) ? a_q : b_q)
                : (((op_q == FP_CMP_FMIN) == lt) ? a_q : b_q);
  assign data = (op_q == FP_CMP_FEQ) ? {32'b0, eq}
              : (op_q == FP_CMP_FLT) ? {32'b0, lt}
              : (op_q == FP_CMP_FLE) ? {32'b0, lt | eq}
              : (op_q <= FP_CMP_FMAX) ? minmax : '0;
  assign flags = (op_q > FP_CMP_FMAX) ? '0 : core_flags;
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      last_grant     <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_src   <= 1'b0;
      bus.resp_tag   <= '0;
      bus.resp_data  <= '0;
      bus.resp_flags <= '0;
      bus.fflags_acc <= '0;
    end else begin
      state <= bus.flush ? ST_IDLE
             : (state == ST_EXEC) ? ST_RESP
             : ((state == ST_RESP) & ~bus.resp_ready) ? ST_RESP
             : accept ? ST_EXEC : ST_IDLE;
      bus.resp_valid <= ~bus.flush & ((state == ST_EXEC) | ((state == ST_RESP) & ~bus.resp_ready));
      bus.fflags_acc <= (bus.fflags_clr ? 5'b0 : bus.fflags_acc) |
                        ((bus.resp_valid & bus.resp_ready) ? bus.resp_flags : 5'b0);
      if (accept) begin
        last_grant <= grant1;
        src_q      <= grant1;
        op_q       <= grant1 ? bus.req1_op  : bus.req0_op;
        a_q        <= grant1 ? bus.req1_a   : bus.req0_a;
        b_q        <= grant1 ? bus.req1_b   : bus.req0_b;
        tag_q      <= grant1 ? bus.req1_tag : bus.req0_tag;
      end
      if ((state == ST_EXEC) & ~bus.flush) begin
        bus.resp_src   <= src_q;
        bus.resp_tag   <= tag_q;
        bus.resp_data  <= data;
        bus.resp_flags <= flags;
      end
    end
  end
endmodule
